punc_control_fsm: RTL and testbench
===================================

Name: punc_control_fsm

Overview:
- Control unit for the PUnC LC3 processor; the counterpart of the PUnC datapath control interface.
- Consumes the datapath's `ir_out` and `nzp_match` and drives every datapath load, clear, strobe and mux-select each cycle.
- Sequences fetch, decode and execute for the PUnC LC3 subset, and stops in a terminal state on HALT.
- All select encodings are the team's `Defines.v` macros (`PC_Data_Sel_*`, `DMem_*_Addr_Sel_*`, `RF_*_Sel_*`, `ALU_*`).

Parameters:
- HALT_OPCODE, 4'b1111, `ir[15:12]` value that enters HALT.
- STATE_W, 3, width of the internal state register.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ir_out  input  16  current instruction register from the datapath.
- nzp_match  input  1  branch condition match from the datapath.
- pc_ld, pc_clr, pc_inc  output  1 each  PC controls.
- pc_sel  output  2  PC source select.
- ir_ld, ir_clr  output  1 each  IR controls.
- dmem_rd, dmem_wr  output  1 each  data memory strobes.
- dmem_r_addr_sel, dmem_w_addr_sel  output  2 each  memory address selects.
- rf_w_data_sel  output  2  register-file write data select.
- rf_w_addr_sel, rf_w_wr  output  1 each  register-file write address select and write enable.
- rf_rp_addr_sel, rf_rp_rd, rf_rq_rd  output  1 each  register-file read controls.
- temp_ld  output  1  temp register load.
- nzp_ld, nzp_clr  output  1 each  condition-code controls.
- alu_sel  output  2  ALU function select.
- alu_in_a_sel  output  1  ALU input A select.
- halted  output  1  high while in HALT.

Behaviour:
- States: INIT, FETCH, DECODE, EXEC, EXEC2, HALT. The state is registered; all outputs are a combinational decode of state and `ir_out`.
- Default for every output in every state: 0. All selects default to 0.
- While `rst` is low: state=INIT asynchronously, so all strobes are 0 and `halted`=0.
- INIT: assert `pc_clr`, `ir_clr`, `nzp_clr` for exactly one cycle; next state FETCH.
- FETCH: `dmem_rd`=1, `dmem_r_addr_sel`=PC, `ir_ld`=1, `pc_inc`=1; next state DECODE.
- DECODE: no strobes. Next state is HALT if `ir[15:12]`=HALT_OPCODE, otherwise EXEC.
- EXEC, by opcode (`ir[15:12]`); returns to FETCH unless stated otherwise:
  - ADD 0001 / AND 0101:
    - `rf_rq_rd`=1.
    - If `ir[5]`=1: `alu_in_a_sel`=4_0. Else: `rf_rp_addr_sel`=2_0, `rf_rp_rd`=1, `alu_in_a_sel`=Rp.
    - `alu_sel`=ADD or AND.
    - `rf_w_data_sel`=ALU, `rf_w_addr_sel`=11_9, `rf_w_wr`=1, `nzp_ld`=1.
  - NOT 1001: `alu_sel`=NOT_B, `rf_rq_rd`=1; write Rd from ALU; `nzp_ld`=1.
  - BR 0000: `pc_sel`=PC_8_0; `pc_ld`=`nzp_match`.
  - JMP 1100: `pc_sel`=RF_Rq_Data, `rf_rq_rd`=1, `pc_ld`=1.
  - JSR/JSRR 0100:
    - `rf_w_data_sel`=PC, `rf_w_addr_sel`=R7, `rf_w_wr`=1, `pc_ld`=1.
    - `pc_sel`=PC_10_0 if `ir[11]`=1, else RF_Rq_Data with `rf_rq_rd`=1.
    - The R7 write and the PC load occur on the same edge, so JSRR R7 jumps to the old R7.
  - LD 0010: `dmem_rd`=1, `dmem_r_addr_sel`=PC_8_0, `rf_w_data_sel`=DMem_R; write Rd; `nzp_ld`=1.
  - LDR 0110: as LD, but `dmem_r_addr_sel`=RF_Rq_5_0 and `rf_rq_rd`=1.
  - LEA 1110: `rf_w_data_sel`=PC_8_0; write Rd; `nzp_ld`=1.
  - ST 0011: `rf_rp_addr_sel`=11_9, `rf_rp_rd`=1, `dmem_w_addr_sel`=PC_8_0, `dmem_wr`=1.
  - STR 0111: as ST, but `dmem_w_addr_sel`=RF_Rq_5_0 and `rf_rq_rd`=1.
  - LDI 1010:
    - EXEC: read at PC_8_0 and write the pointer into Rd (no `nzp_ld`); next state EXEC2.
    - EXEC2: `rf_rp_addr_sel`=11_9, `rf_rp_rd`=1, `dmem_r_addr_sel`=RF_Rp_Data, `dmem_rd`=1; write Rd from DMem_R; `nzp_ld`=1.
  - STI 1011:
    - EXEC: `dmem_rd`=1, `dmem_r_addr_sel`=PC_8_0, `temp_ld`=1; next state EXEC2.
    - EXEC2: `dmem_w_addr_sel`=Temp_Data, `rf_rp_addr_sel`=11_9, `rf_rp_rd`=1, `dmem_wr`=1.
  - 1000, 1101: no-op.
- HALT: `halted`=1, no strobes, self-loop. Only reset exits HALT.
- Latency:
  - Most instructions: 3 cycles (FETCH, DECODE, EXEC).
  - LDI/STI: 4 cycles.
  - The first FETCH occurs one cycle after `rst` rises.
- Reset mid-instruction (including in EXEC2): state returns to INIT immediately and no partial strobe survives.

Optional Feature:
- Macro: PUNC_ILLEGAL_HALT_EN.
- Defined:
  - Opcodes 1000 and 1101 transition DECODE→HALT.
  - An extra output `illegal_op` (1 bit) is set in that DECODE cycle, stays 1 while in HALT, and is cleared by reset.
- Undefined: 1000 and 1101 execute as no-ops and the `illegal_op` port is absent.

Test Plan:
- Reset, then release → one cycle with `pc_clr`=`ir_clr`=`nzp_clr`=1, then FETCH with `ir_ld`=`pc_inc`=1. With the datapath: PC=1 after fetching word 0.
- Program R1=3; ADD R1,R1,#5 (0x1265) → in EXEC: `rf_w_wr`=1, `alu_in_a_sel`=4_0, `nzp_ld`=1; R1=8 and p=1 after 3 cycles.
- BRz #2 with z=0, then with z=1 → `pc_ld`=0 and the PC stays at the increment; then `pc_ld`=1 and the PC advances by 3 from the instruction address.
- LDI R2,#1 with mem[PC+1]=0x0020, mem[0x20]=0x8000 → 4 cycles per instruction, EXEC2 asserts `dmem_rd`, R2=0x8000, n=1.
- STI R3,#1 with pointer 0x0030, R3=0x1234 → `temp_ld` in EXEC, `dmem_wr` in EXEC2, mem[0x30]=0x1234.
- HALT (0xF025) → `halted`=1 indefinitely with no strobes. Pulse `rst` low mid-EXEC2 of an STI → `dmem_wr` never asserts, and INIT follows.

Source files
------------

// File: rtl/punc_control_fsm_if.sv
// Control bus between the PUnC control FSM (master) and the PUnC datapath (slave).
// illegal_op exists only when PUNC_ILLEGAL_HALT_EN is defined.
interface punc_control_fsm_if;
   logic [15:0] ir_out;
   logic        nzp_match;
   logic        pc_ld;
   logic        pc_clr;
   logic        pc_inc;
   logic [1:0]  pc_sel;
   logic        ir_ld;
   logic        ir_clr;
   logic        dmem_rd;
   logic        dmem_wr;
   logic [1:0]  dmem_r_addr_sel;
   logic [1:0]  dmem_w_addr_sel;
   logic [1:0]  rf_w_data_sel;
   logic        rf_w_addr_sel;
   logic        rf_w_wr;
   logic        rf_rp_addr_sel;
   logic        rf_rp_rd;
   logic        rf_rq_rd;
   logic        temp_ld;
   logic        nzp_ld;
   logic        nzp_clr;
   logic [1:0]  alu_sel;
   logic        alu_in_a_sel;
   logic        halted;
`ifdef PUNC_ILLEGAL_HALT_EN
   logic        illegal_op;
`endif

   modport master (
      input  ir_out, nzp_match,
      output pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr,
      output dmem_rd, dmem_wr, dmem_r_addr_sel, dmem_w_addr_sel,
      output rf_w_data_sel, rf_w_addr_sel, rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd,
      output temp_ld, nzp_ld, nzp_clr, alu_sel, alu_in_a_sel, halted
`ifdef PUNC_ILLEGAL_HALT_EN
      , output illegal_op
`endif
   );

   modport slave (
      output ir_out, nzp_match,
      input  pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr,
      input  dmem_rd, dmem_wr, dmem_r_addr_sel, dmem_w_addr_sel,
      input  rf_w_data_sel, rf_w_addr_sel, rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd,
      input  temp_ld, nzp_ld, nzp_clr, alu_sel, alu_in_a_sel, halted
`ifdef PUNC_ILLEGAL_HALT_EN
      , input illegal_op
`endif
   );
endinterface

// File: rtl/punc_control_fsm.sv
// PUnC LC3 control unit: fetch/decode/execute sequencer driving the datapath control bus.
// Optional macro PUNC_ILLEGAL_HALT_EN: opcodes 1000/1101 halt and raise illegal_op.
module punc_control_fsm #(
   parameter logic [3:0] HALT_OPCODE = 4'b1111,
   parameter int         STATE_W     = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   punc_control_fsm_if.master   bus
);
   localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011,
                          OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
                          OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                          OP_LEA = 4'b1110;

   localparam logic [1:0] PC_Data_Sel_PC_8_0         = 2'd0;
   localparam logic [1:0] PC_Data_Sel_PC_10_0        = 2'd1;
   localparam logic [1:0] PC_Data_Sel_RF_Rq_Data     = 2'd2;
   localparam logic [1:0] DMem_R_Addr_Sel_PC         = 2'd0;
   localparam logic [1:0] DMem_R_Addr_Sel_PC_8_0     = 2'd1;
   localparam logic [1:0] DMem_R_Addr_Sel_RF_Rq_5_0  = 2'd2;
   localparam logic [1:0] DMem_R_Addr_Sel_RF_Rp_Data = 2'd3;
   localparam logic [1:0] DMem_W_Addr_Sel_PC_8_0     = 2'd0;
   localparam logic [1:0] DMem_W_Addr_Sel_RF_Rq_5_0  = 2'd1;
   localparam logic [1:0] DMem_W_Addr_Sel_Temp_Data  = 2'd2;
   localparam logic [1:0] RF_W_Data_Sel_ALU          = 2'd0;
   localparam logic [1:0] RF_W_Data_Sel_PC           = 2'd1;
   localparam logic [1:0] RF_W_Data_Sel_PC_8_0       = 2'd2;
   localparam logic [1:0] RF_W_Data_Sel_DMem_R       = 2'd3;
   localparam logic       RF_W_Addr_Sel_11_9         = 1'b0;
   localparam logic       RF_W_Addr_Sel_R7           = 1'b1;
   localparam logic       RF_Rp_Addr_Sel_2_0         = 1'b0;
   localparam logic       RF_Rp_Addr_Sel_11_9        = 1'b1;
   localparam logic [1:0] ALU_ADD                    = 2'd0;
   localparam logic [1:0] ALU_AND                    = 2'd1;
   localparam logic [1:0] ALU_NOT_B                  = 2'd2;
   localparam logic       ALU_In_A_Sel_Rp            = 1'b0;
   localparam logic       ALU_In_A_Sel_4_0           = 1'b1;

   typedef enum logic [STATE_W-1:0] {
      S_INIT   = STATE_W'(0),
      S_FETCH  = STATE_W'(1),
      S_DECODE = STATE_W'(2),
      S_EXEC   = STATE_W'(3),
      S_EXEC2  = STATE_W'(4),
      S_HALT   = STATE_W'(5)
   } state_t;

   state_t     r_state;
   logic [3:0] w_opcode;
   logic       w_illegal;
   logic       w_unused_ir;

   assign w_opcode    = bus.ir_out[15:12];
   assign w_unused_ir = ^{bus.ir_out[10:6], bus.ir_out[4:0]};

`ifdef PUNC_ILLEGAL_HALT_EN
   logic r_illegal_op;
   assign w_illegal      = (w_opcode == 4'b1000) || (w_opcode == 4'b1101);
   assign bus.illegal_op = r_illegal_op | (rst & (r_state == S_DECODE) & w_illegal);
`else
   assign w_illegal = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_INIT;
`ifdef PUNC_ILLEGAL_HALT_EN
         r_illegal_op <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_INIT:   r_state <= S_FETCH;
            S_FETCH:  r_state <= S_DECODE;
            S_DECODE: begin
               if (w_opcode == HALT_OPCODE || w_illegal) r_state <= S_HALT;
               else                                      r_state <= S_EXEC;
`ifdef PUNC_ILLEGAL_HALT_EN
               if (w_illegal) r_illegal_op <= 1'b1;
`endif
            end
            S_EXEC:   r_state <= (w_opcode == OP_LDI || w_opcode == OP_STI) ? S_EXEC2 : S_FETCH;
            S_EXEC2:  r_state <= S_FETCH;
            S_HALT:   r_state <= S_HALT;
            default:  r_state <= S_INIT;
         endcase
      end
   end

   // Outputs are gated by rst so nothing, not even the INIT clears, leaks out while reset is held.
   always_comb begin
      bus.pc_ld           = 1'b0;
      bus.pc_clr          = 1'b0;
      bus.pc_inc          = 1'b0;
      bus.pc_sel          = 2'd0;
      bus.ir_ld           = 1'b0;
      bus.ir_clr          = 1'b0;
      bus.dmem_rd         = 1'b0;
      bus.dmem_wr         = 1'b0;
      bus.dmem_r_addr_sel = 2'd0;
      bus.dmem_w_addr_sel = 2'd0;
      bus.rf_w_data_sel   = 2'd0;
      bus.rf_w_addr_sel   = 1'b0;
      bus.rf_w_wr         = 1'b0;
      bus.rf_rp_addr_sel  = 1'b0;
      bus.rf_rp_rd        = 1'b0;
      bus.rf_rq_rd        = 1'b0;
      bus.temp_ld         = 1'b0;
      bus.nzp_ld          = 1'b0;
      bus.nzp_clr         = 1'b0;
      bus.alu_sel         = 2'd0;
      bus.alu_in_a_sel    = 1'b0;
      bus.halted          = 1'b0;
      if (rst) begin
         case (r_state)
            S_INIT: begin
               bus.pc_clr  = 1'b1;
               bus.ir_clr  = 1'b1;
               bus.nzp_clr = 1'b1;
            end
            S_FETCH: begin
               bus.dmem_rd         = 1'b1;
               bus.dmem_r_addr_sel = DMem_R_Addr_Sel_PC;
               bus.ir_ld           = 1'b1;
               bus.pc_inc          = 1'b1;
            end
            S_EXEC, S_EXEC2: begin
               case (w_opcode)
                  OP_ADD, OP_AND: begin
                     bus.rf_rq_rd = 1'b1;
                     if (bus.ir_out[5]) begin
                        bus.alu_in_a_sel = ALU_In_A_Sel_4_0;
                     end else begin
                        bus.rf_rp_addr_sel = RF_Rp_Addr_Sel_2_0;
                        bus.rf_rp_rd       = 1'b1;
                        bus.alu_in_a_sel   = ALU_In_A_Sel_Rp;
                     end
                     bus.alu_sel       = (w_opcode == OP_AND) ? ALU_AND : ALU_ADD;
                     bus.rf_w_data_sel = RF_W_Data_Sel_ALU;
                     bus.rf_w_addr_sel = RF_W_Addr_Sel_11_9;
                     bus.rf_w_wr       = 1'b1;
                     bus.nzp_ld        = 1'b1;
                  end
                  OP_NOT: begin
                     bus.alu_sel       = ALU_NOT_B;
                     bus.rf_rq_rd      = 1'b1;
                     bus.rf_w_data_sel = RF_W_Data_Sel_ALU;
                     bus.rf_w_addr_sel = RF_W_Addr_Sel_11_9;
                     bus.rf_w_wr       = 1'b1;
                     bus.nzp_ld        = 1'b1;
                  end
                  OP_BR: begin
                     bus.pc_sel = PC_Data_Sel_PC_8_0;
                     bus.pc_ld  = bus.nzp_match;
                  end
                  OP_JMP: begin
                     bus.pc_sel   = PC_Data_Sel_RF_Rq_Data;
                     bus.rf_rq_rd = 1'b1;
                     bus.pc_ld    = 1'b1;
                  end
                  OP_JSR: begin
                     // R7 write and PC load share one edge, so JSRR R7 uses the old R7.
                     bus.rf_w_data_sel = RF_W_Data_Sel_PC;
                     bus.rf_w_addr_sel = RF_W_Addr_Sel_R7;
                     bus.rf_w_wr       = 1'b1;
                     bus.pc_ld         = 1'b1;
                     if (bus.ir_out[11]) begin
                        bus.pc_sel = PC_Data_Sel_PC_10_0;
                     end else begin
                        bus.pc_sel   = PC_Data_Sel_RF_Rq_Data;
                        bus.rf_rq_rd = 1'b1;
                     end
                  end
                  OP_LD, OP_LDR: begin
                     bus.dmem_rd         = 1'b1;
                     bus.dmem_r_addr_sel = (w_opcode == OP_LDR) ? DMem_R_Addr_Sel_RF_Rq_5_0
                                                                : DMem_R_Addr_Sel_PC_8_0;
                     bus.rf_rq_rd        = (w_opcode == OP_LDR);
                     bus.rf_w_data_sel   = RF_W_Data_Sel_DMem_R;
                     bus.rf_w_addr_sel   = RF_W_Addr_Sel_11_9;
                     bus.rf_w_wr         = 1'b1;
                     bus.nzp_ld          = 1'b1;
                  end
                  OP_LEA: begin
                     bus.rf_w_data_sel = RF_W_Data_Sel_PC_8_0;
                     bus.rf_w_addr_sel = RF_W_Addr_Sel_11_9;
                     bus.rf_w_wr       = 1'b1;
                     bus.nzp_ld        = 1'b1;
                  end
                  OP_ST, OP_STR: begin
                     bus.rf_rp_addr_sel  = RF_Rp_Addr_Sel_11_9;
                     bus.rf_rp_rd        = 1'b1;
                     bus.dmem_w_addr_sel = (w_opcode == OP_STR) ? DMem_W_Addr_Sel_RF_Rq_5_0
                                                                : DMem_W_Addr_Sel_PC_8_0;
                     bus.rf_rq_rd        = (w_opcode == OP_STR);
                     bus.dmem_wr         = 1'b1;
                  end
                  OP_LDI: begin
                     bus.dmem_rd       = 1'b1;
                     bus.rf_w_data_sel = RF_W_Data_Sel_DMem_R;
                     bus.rf_w_addr_sel = RF_W_Addr_Sel_11_9;
                     bus.rf_w_wr       = 1'b1;
                     if (r_state == S_EXEC) begin
                        bus.dmem_r_addr_sel = DMem_R_Addr_Sel_PC_8_0;
                     end else begin
                        // Rd holds the pointer fetched in the first execute cycle.
                        bus.rf_rp_addr_sel  = RF_Rp_Addr_Sel_11_9;
                        bus.rf_rp_rd        = 1'b1;
                        bus.dmem_r_addr_sel = DMem_R_Addr_Sel_RF_Rp_Data;
                        bus.nzp_ld          = 1'b1;
                     end
                  end
                  OP_STI: begin
                     if (r_state == S_EXEC) begin
                        bus.dmem_rd         = 1'b1;
                        bus.dmem_r_addr_sel = DMem_R_Addr_Sel_PC_8_0;
                        bus.temp_ld         = 1'b1;
                     end else begin
                        bus.dmem_w_addr_sel = DMem_W_Addr_Sel_Temp_Data;
                        bus.rf_rp_addr_sel  = RF_Rp_Addr_Sel_11_9;
                        bus.rf_rp_rd        = 1'b1;
                        bus.dmem_wr         = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            S_HALT:  bus.halted = 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_punc_control_fsm.sv
// Bench for punc_control_fsm: small PC/IR datapath stand-in, instruction-level model, per-cycle compare.
module tb_punc_control_fsm;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   punc_control_fsm_if bus ();
   punc_control_fsm #(.HALT_OPCODE(4'b1111), .STATE_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

   localparam logic [1:0] PCS_8_0 = 2'd0, PCS_10_0 = 2'd1, PCS_RQ = 2'd2;
   localparam logic [1:0] RA_PC = 2'd0, RA_8_0 = 2'd1, RA_RQ = 2'd2, RA_RP = 2'd3;
   localparam logic [1:0] WA_8_0 = 2'd0, WA_RQ = 2'd1, WA_TEMP = 2'd2;
   localparam logic [1:0] WD_ALU = 2'd0, WD_PC = 2'd1, WD_8_0 = 2'd2, WD_DMEM = 2'd3;

   typedef struct packed {
      logic pc_ld; logic pc_clr; logic pc_inc; logic [1:0] pc_sel;
      logic ir_ld; logic ir_clr; logic dmem_rd; logic dmem_wr;
      logic [1:0] r_addr; logic [1:0] w_addr; logic [1:0] wd_sel;
      logic wa_r7; logic w_wr; logic rp_11_9; logic rp_rd; logic rq_rd;
      logic temp_ld; logic nzp_ld; logic nzp_clr; logic [1:0] alu_sel; logic alu_imm;
      logic halted; logic illegal;
   } ctl_t;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- datapath stand-in ----------------
   logic [15:0] rom [0:63];
   logic [15:0] pc_q = 16'd0;
   logic [15:0] ir_q = 16'd0;
   logic [5:0]  ir_addr = 6'd0;
   logic [63:0] br_cond = 64'd8;   // only the branch at address 3 is taken
   int          cyc = 0;
   int          wr_count = 0;
   logic [15:0] fetch_pc [$];
   int          fetch_cyc [$];

   assign bus.ir_out    = ir_q;
   assign bus.nzp_match = br_cond[ir_addr];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.pc_clr) pc_q <= 16'd0;
      else if (bus.pc_ld) begin
         case (bus.pc_sel)
            PCS_8_0:  pc_q <= pc_q + {{7{ir_q[8]}}, ir_q[8:0]};
            PCS_10_0: pc_q <= pc_q + {{5{ir_q[10]}}, ir_q[10:0]};
            default:  pc_q <= 16'd16 + {13'd0, ir_q[8:6]};
         endcase
      end else if (bus.pc_inc) pc_q <= pc_q + 16'd1;
      if (bus.ir_clr) ir_q <= 16'd0;
      else if (bus.ir_ld) begin
         ir_q    <= rom[pc_q[5:0]];
         ir_addr <= pc_q[5:0];
      end
      if (rst && bus.ir_ld) begin
         fetch_pc.push_back(pc_q);
         fetch_cyc.push_back(cyc);
      end
      if (rst && bus.dmem_wr) wr_count <= wr_count + 1;
   end

   // ---------------- instruction-level model ----------------
   bit m_init = 1'b1;
   bit m_halt = 1'b0;
   bit m_ill  = 1'b0;
   int m_k    = 0;    // cycle index within the current instruction, 0 = fetch

   function automatic bit is_illegal(input logic [3:0] op);
`ifdef PUNC_ILLEGAL_HALT_EN
      return (op == 4'b1000) || (op == 4'b1101);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int instr_len(input logic [3:0] op);
      return (op == 4'b1010 || op == 4'b1011) ? 4 : 3;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_init <= 1'b1; m_halt <= 1'b0; m_ill <= 1'b0; m_k <= 0;
      end else if (m_init) begin
         m_init <= 1'b0; m_k <= 0;
      end else if (!m_halt) begin
         if (m_k == 1 && (ir_q[15:12] == 4'hF || is_illegal(ir_q[15:12]))) begin
            m_halt <= 1'b1;
            m_ill  <= is_illegal(ir_q[15:12]);
         end else if (m_k + 1 == instr_len(ir_q[15:12])) m_k <= 0;
         else m_k <= m_k + 1;
      end
   end

   function automatic ctl_t exec_word(input logic [15:0] ir, input bit second, input logic match);
      ctl_t c = '0;
      case (ir[15:12])
         4'h1, 4'h5: begin
            c.rq_rd = 1; c.w_wr = 1; c.nzp_ld = 1; c.wd_sel = WD_ALU;
            c.alu_sel = (ir[15:12] == 4'h5) ? 2'd1 : 2'd0;
            if (ir[5]) c.alu_imm = 1; else c.rp_rd = 1;
         end
         4'h9: begin c.alu_sel = 2'd2; c.rq_rd = 1; c.w_wr = 1; c.nzp_ld = 1; end
         4'h0: begin c.pc_sel = PCS_8_0; c.pc_ld = match; end
         4'hC: begin c.pc_sel = PCS_RQ; c.rq_rd = 1; c.pc_ld = 1; end
         4'h4: begin
            c.wd_sel = WD_PC; c.wa_r7 = 1; c.w_wr = 1; c.pc_ld = 1;
            if (ir[11]) c.pc_sel = PCS_10_0; else begin c.pc_sel = PCS_RQ; c.rq_rd = 1; end
         end
         4'h2: begin c.dmem_rd = 1; c.r_addr = RA_8_0; c.wd_sel = WD_DMEM; c.w_wr = 1; c.nzp_ld = 1; end
         4'h6: begin c.dmem_rd = 1; c.r_addr = RA_RQ; c.rq_rd = 1; c.wd_sel = WD_DMEM; c.w_wr = 1; c.nzp_ld = 1; end
         4'hE: begin c.wd_sel = WD_8_0; c.w_wr = 1; c.nzp_ld = 1; end
         4'h3: begin c.rp_11_9 = 1; c.rp_rd = 1; c.w_addr = WA_8_0; c.dmem_wr = 1; end
         4'h7: begin c.rp_11_9 = 1; c.rp_rd = 1; c.w_addr = WA_RQ; c.rq_rd = 1; c.dmem_wr = 1; end
         4'hA: begin
            c.dmem_rd = 1; c.wd_sel = WD_DMEM; c.w_wr = 1;
            if (!second) c.r_addr = RA_8_0;
            else begin c.rp_11_9 = 1; c.rp_rd = 1; c.r_addr = RA_RP; c.nzp_ld = 1; end
         end
         4'hB: begin
            if (!second) begin c.dmem_rd = 1; c.r_addr = RA_8_0; c.temp_ld = 1; end
            else begin c.w_addr = WA_TEMP; c.rp_11_9 = 1; c.rp_rd = 1; c.dmem_wr = 1; end
         end
         default: ;
      endcase
      return c;
   endfunction

   function automatic ctl_t expected_word();
      ctl_t c = '0;
      if (!rst) return c;
      if (m_init) begin c.pc_clr = 1; c.ir_clr = 1; c.nzp_clr = 1; end
      else if (m_halt) begin c.halted = 1; c.illegal = m_ill; end
      else if (m_k == 0) begin c.dmem_rd = 1; c.r_addr = RA_PC; c.ir_ld = 1; c.pc_inc = 1; end
      else if (m_k == 1) c.illegal = is_illegal(ir_q[15:12]);
      else c = exec_word(ir_q, m_k == 3, bus.nzp_match);
      return c;
   endfunction

   function automatic ctl_t dut_word();
      ctl_t c;
      c.pc_ld = bus.pc_ld; c.pc_clr = bus.pc_clr; c.pc_inc = bus.pc_inc; c.pc_sel = bus.pc_sel;
      c.ir_ld = bus.ir_ld; c.ir_clr = bus.ir_clr; c.dmem_rd = bus.dmem_rd; c.dmem_wr = bus.dmem_wr;
      c.r_addr = bus.dmem_r_addr_sel; c.w_addr = bus.dmem_w_addr_sel; c.wd_sel = bus.rf_w_data_sel;
      c.wa_r7 = bus.rf_w_addr_sel; c.w_wr = bus.rf_w_wr; c.rp_11_9 = bus.rf_rp_addr_sel;
      c.rp_rd = bus.rf_rp_rd; c.rq_rd = bus.rf_rq_rd; c.temp_ld = bus.temp_ld; c.nzp_ld = bus.nzp_ld;
      c.nzp_clr = bus.nzp_clr; c.alu_sel = bus.alu_sel; c.alu_imm = bus.alu_in_a_sel;
      c.halted = bus.halted;
`ifdef PUNC_ILLEGAL_HALT_EN
      c.illegal = bus.illegal_op;
`else
      c.illegal = 1'b0;
`endif
      return c;
   endfunction

   // One control-word comparison per cycle, away from the active edge.
   always @(negedge clk) begin
      ctl_t got, want;
      got  = dut_word();
      want = expected_word();
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL ctl_word t=%0t ir=%h: got %b required %b", $time, ir_q, got, want);
      end
   end

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, got, want);
      end else
         $display("check %s: %0d ok", name, got);
   endtask

   int exp_trace [$];
   int wr_base;
   bit found;

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 16'h1000;
      rom[0]  = 16'h1265; rom[1]  = 16'h5042; rom[2]  = 16'h0402; rom[3]  = 16'h0402;
      rom[6]  = 16'hA401; rom[7]  = 16'hB601; rom[8]  = 16'h967F; rom[9]  = 16'hC080;
      rom[18] = 16'h4802; rom[21] = 16'h4180; rom[22] = 16'h2201; rom[23] = 16'h6242;
      rom[24] = 16'hE205; rom[25] = 16'h3201; rom[26] = 16'h7242; rom[27] = 16'h8000;
      rom[28] = 16'hD000; rom[29] = 16'hB601; rom[30] = 16'hF025;
`ifdef PUNC_ILLEGAL_HALT_EN
      exp_trace = '{0, 1, 2, 3, 6, 7, 8, 9, 18, 21, 22, 23, 24, 25, 26, 27};
`else
      exp_trace = '{0, 1, 2, 3, 6, 7, 8, 9, 18, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30};
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 400 && !bus.halted; i++) @(posedge clk);
      check("reach_halt", int'(bus.halted), 1);

      check("fetch_count", fetch_pc.size(), exp_trace.size());
      for (int i = 0; i < exp_trace.size() && i < fetch_pc.size(); i++)
         check($sformatf("fetch_pc[%0d]", i), int'(fetch_pc[i]), exp_trace[i]);
      if (fetch_cyc.size() > 5) begin
         check("br_latency", fetch_cyc[4] - fetch_cyc[3], 3);
         check("ldi_latency", fetch_cyc[5] - fetch_cyc[4], 4);
      end
      repeat (10) @(posedge clk);
      #1 check("halt_sticky", int'(bus.halted), 1);
      check("halt_no_fetch", int'(bus.ir_ld), 0);

      // Reset pulse in the middle of an STI's second execute cycle.
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      wr_base = wr_count;
      #1 check("init_clears", int'({bus.pc_clr, bus.ir_clr, bus.nzp_clr}), 7);
      @(posedge clk);
      #1 check("first_fetch", int'({bus.ir_ld, bus.pc_inc}), 3);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (!m_init && !m_halt && m_k == 3 && ir_q[15:12] == 4'hB) begin
            found = 1'b1;
            break;
         end
      end
      check("sti_exec2_found", int'(found), 1);
      check("sti_exec2_wr", int'(bus.dmem_wr), 1);
      #1 rst = 1'b0;
      #1 check("reset_kills_wr", int'(bus.dmem_wr), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check("init_after_reset", int'(bus.pc_clr), 1);
      repeat (2) @(posedge clk);
      #1 check("no_store_done", wr_count - wr_base, 0);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
